// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle RV32 subset (lw/lbu, sw/sb, R/I ALU, beq/bne, jal, lui).
// Define MEMRDY_EN to add the mem_ready handshake that stalls FETCH, MEMREAD and MEMWRITE.
module multicycle_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       zero,
`ifdef MEMRDY_EN
   input  logic       mem_ready,
`endif
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       AdrSrc,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [2:0] ImmSrc,
   output logic       ByteEn,
   output logic       illegal,
   output logic [3:0] state
);
   // state    | meaning
   // FETCH    | read instruction, PC += 4
   // DECODE   | read registers, compute branch/jal target
   // MEMADR   | compute load/store address
   // MEMREAD  | data memory read
   // MEMWB    | write loaded data to register
   // MEMWRITE | data memory write
   // EXECR    | register-register ALU op
   // EXECI    | register-immediate ALU op
   // ALUWB    | write ALU result to register
   // BRANCH   | compare, conditionally load PC
   // JAL      | load PC with target, compute link
   // LUI      | pass upper immediate through ALU
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_LUI      = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   state_t state_q, state_d;
   logic   mem_rdy;
   logic   pc_write, ir_write, mem_write, reg_write, illegal_dec;

`ifdef MEMRDY_EN
   assign mem_rdy = mem_ready;
`else
   assign mem_rdy = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = S_FETCH;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      illegal_dec = 1'b0;
      AdrSrc      = 1'b0;
      ResultSrc   = 2'b00;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      ByteEn      = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_write  = mem_rdy;
            pc_write  = mem_rdy;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            state_d   = mem_rdy ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXECR;
               OP_I:              state_d = S_EXECI;
               OP_B:              state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_LUI:            state_d = S_LUI;
               default: begin
                  illegal_dec = 1'b1;
                  state_d     = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            AdrSrc  = 1'b1;
            ByteEn  = (funct3[1:0] == 2'b00);
            state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            reg_write = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc    = 1'b1;
            mem_write = 1'b1;
            ByteEn    = (funct3[1:0] == 2'b00);
            state_d   = mem_rdy ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
            state_d = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
            state_d = S_ALUWB;
         end
         S_ALUWB: reg_write = 1'b1;
         S_BRANCH: begin
            ALUSrcA  = 2'b10;
            ALUOp    = 2'b01;
            pc_write = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
         end
         S_JAL: begin
            ALUSrcA  = 2'b01;
            ALUSrcB  = 2'b10;
            pc_write = 1'b1;
            state_d  = S_ALUWB;
         end
         S_LUI: begin
            ALUSrcB = 2'b01;
            ALUOp   = 2'b11;
            state_d = S_ALUWB;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      case (op)
         OP_STORE: ImmSrc = 3'b001;
         OP_B:     ImmSrc = 3'b010;
         OP_JAL:   ImmSrc = 3'b011;
         OP_LUI:   ImmSrc = 3'b100;
         default:  ImmSrc = 3'b000;
      endcase
   end

   // Reset gates the enables directly so FETCH's defaults cannot write while rst_n is low.
   assign PCWrite  = pc_write    & rst_n;
   assign IRWrite  = ir_write    & rst_n;
   assign MemWrite = mem_write   & rst_n;
   assign RegWrite = reg_write   & rst_n;
   assign illegal  = illegal_dec & rst_n;
   assign state    = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction stream checked against a per-instruction state-sequence model.
module tb_multicycle_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       zero;
`ifdef MEMRDY_EN
   logic       mem_ready;
`endif
   logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ByteEn, illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
   logic [2:0] ImmSrc;
   logic [3:0] state;

   int n_vec = 0;
   int n_err = 0;
   int seq[$];
   int mr_hold = 0;

   always #5 clk = ~clk;

   multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero),
`ifdef MEMRDY_EN
      .mem_ready(mem_ready),
`endif
      .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .ImmSrc(ImmSrc), .ByteEn(ByteEn), .illegal(illegal), .state(state)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (op=%b f3=%b t=%0t)", tag, got, exp, op, funct3, $time);
      end
   endtask

   function automatic logic [17:0] dut_outs();
      return {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
              ALUOp, ImmSrc, ByteEn, illegal};
   endfunction

   function automatic bit is_legal(input logic [6:0] o);
      return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                       7'b1100011, 7'b1101111, 7'b0110111};
   endfunction

   // Expected state walk for one instruction, FETCH through its last state.
   function automatic void build_seq(input logic [6:0] o);
      seq.delete();
      seq.push_back(0);
      seq.push_back(1);
      case (o)
         7'b0000011: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
         7'b0100011: begin seq.push_back(2); seq.push_back(5); end
         7'b0110011: begin seq.push_back(6); seq.push_back(8); end
         7'b0010011: begin seq.push_back(7); seq.push_back(8); end
         7'b1100011: seq.push_back(9);
         7'b1101111: begin seq.push_back(10); seq.push_back(8); end
         7'b0110111: begin seq.push_back(11); seq.push_back(8); end
         default: ;
      endcase
   endfunction

   function automatic logic [17:0] exp_outs(input int st, input logic [6:0] o, input logic [2:0] f3,
                                            input logic z, input logic mr, input bit in_rst);
      logic pcw = 0, irw = 0, mw = 0, rw = 0, adr = 0, be = 0, ill = 0;
      logic [1:0] rs = 0, sa = 0, sb = 0, aop = 0;
      logic [2:0] imm;
      case (o)
         7'b0100011: imm = 3'b001;
         7'b1100011: imm = 3'b010;
         7'b1101111: imm = 3'b011;
         7'b0110111: imm = 3'b100;
         default:    imm = 3'b000;
      endcase
      case (st)
         0: begin irw = mr; pcw = mr; sb = 2'b10; rs = 2'b10; end
         1: begin sa = 2'b01; sb = 2'b01; ill = !is_legal(o); end
         2: begin sa = 2'b10; sb = 2'b01; end
         3: begin adr = 1; be = (f3[1:0] == 2'b00); end
         4: begin rs = 2'b01; rw = 1; end
         5: begin adr = 1; mw = 1; be = (f3[1:0] == 2'b00); end
         6: begin sa = 2'b10; aop = 2'b10; end
         7: begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
         8: rw = 1;
         9: begin sa = 2'b10; aop = 2'b01; pcw = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z); end
         10: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
         11: begin sb = 2'b01; aop = 2'b11; end
         default: ;
      endcase
      if (in_rst) begin pcw = 0; irw = 0; mw = 0; rw = 0; ill = 0; end
      return {pcw, irw, mw, rw, adr, rs, sa, sb, aop, imm, be, ill};
   endfunction

   // Runs one instruction; abort_at >= 0 pulses reset while in that sequence position.
   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input int abort_at, input int zforce);
      int  idx = 0;
      int  cyc = 0;
      logic mr;
      op = o;
      funct3 = f3;
      build_seq(o);
      while (idx < seq.size() && cyc < 60) begin
         zero = (zforce < 0) ? 1'($urandom_range(0, 1)) : zforce[0];
`ifdef MEMRDY_EN
         if (mr_hold > 0) begin mem_ready = 1'b0; mr_hold--; end
         else mem_ready = ($urandom_range(0, 3) != 0);
         mr = mem_ready;
`else
         mr = 1'b1;
`endif
         @(negedge clk);
         chk("state", 32'(state), 32'(seq[idx]));
         chk("outs", 32'(dut_outs()), 32'(exp_outs(seq[idx], o, f3, zero, mr, 0)));
         if (idx == abort_at) begin
            #1 rst_n = 1'b0;
            #1;
            chk("rst_state", 32'(state), 32'd0);
            chk("rst_outs", 32'(dut_outs()), 32'(exp_outs(0, o, f3, zero, mr, 1)));
            @(posedge clk);
            #1 rst_n = 1'b1;
            return;
         end
         if (!((seq[idx] inside {0, 3, 5}) && !mr)) idx++;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (idx < seq.size()) chk("timeout", 32'(idx), 32'(seq.size()));
   endtask

   initial begin
      logic [6:0] legal_ops[7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                   7'b1100011, 7'b1101111, 7'b0110111};
      logic [6:0] ro;
      int ab;
      rst_n = 1'b0;
      op = 7'b0000011;
      funct3 = 3'b000;
      zero = 1'b0;
`ifdef MEMRDY_EN
      mem_ready = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_outs", 32'(dut_outs()), 32'(exp_outs(0, op, funct3, zero, 1'b1, 1)));
      @(posedge clk);
      #1 rst_n = 1'b1;

`ifdef MEMRDY_EN
      mr_hold = 3;
`endif
      run_instr(7'b0000011, 3'b010, -1, -1);  // lw
      run_instr(7'b0000011, 3'b100, -1, -1);  // lbu
      run_instr(7'b0100011, 3'b000, -1, -1);  // sb
      run_instr(7'b0100011, 3'b010, -1, -1);  // sw
      run_instr(7'b1100011, 3'b000, -1, 1);   // beq taken
      run_instr(7'b1100011, 3'b001, -1, 1);   // bne not taken
      run_instr(7'b1100011, 3'b001, -1, 0);   // bne taken
      run_instr(7'b1100011, 3'b100, -1, 1);   // unsupported branch funct3
      run_instr(7'b1111111, 3'b000, -1, -1);  // illegal
      run_instr(7'b0100011, 3'b010, 3, -1);   // reset during MEMWRITE
      run_instr(7'b0110011, 3'b000, -1, -1);
      run_instr(7'b0010011, 3'b000, -1, -1);
      run_instr(7'b1101111, 3'b000, -1, -1);
      run_instr(7'b0110111, 3'b000, -1, -1);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 8) < 7) ro = legal_ops[$urandom_range(0, 6)];
         else ro = 7'($urandom_range(0, 127));
         ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
`ifdef MEMRDY_EN
         if ($urandom_range(0, 7) == 0) mr_hold = $urandom_range(1, 4);
`endif
         run_instr(ro, 3'($urandom_range(0, 7)), ab, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: op  input  7  opcode field of the held instruction register.
REQ-004 SHALL have port: funct3  input  3  funct3 field of the held instruction.
REQ-005 SHALL have port: zero  input  1  ALU zero flag of the current cycle.
REQ-006 SHALL have ports: PCWrite, IRWrite, MemWrite, RegWrite  output  1 each  write enables.
REQ-007 SHALL have ports: AdrSrc (1), ResultSrc (2), ALUSrcA (2), ALUSrcB (2), ALUOp (2), ImmSrc (3), all outputs, as datapath mux and ALU-decode selects.
REQ-008 SHALL have port: ByteEn  output  1  byte access for lbu/sb; 1 when funct3[1:0]=00 in MEMREAD/MEMWRITE.
REQ-009 SHALL have port: illegal  output  1  one-cycle pulse on unsupported opcode.
REQ-010 SHALL have port: state  output  4  current state encoding, for debug.

Function
REQ-011 SHALL be a Moore FSM with encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, LUI 11; encodings 12-15 SHALL go to FETCH.
REQ-012 SHALL use these transitions:
- FETCH->DECODE.
- DECODE by op: 0000011/0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1100011->BRANCH; 1101111->JAL; 0110111->LUI; any other->FETCH with illegal=1.
- MEMADR->MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD->MEMWB.
- EXECR/EXECI/JAL/LUI->ALUWB.
- MEMWB/MEMWRITE/ALUWB/BRANCH->FETCH.
REQ-013 SHALL drive these per-state outputs; unlisted outputs are 0:
- FETCH: IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
- LUI: ALUSrcB=01, ALUOp=11.
REQ-014 SHALL assert PCWrite in BRANCH only when (funct3=000 and zero=1) or (funct3=001 and zero=0); other funct3 values give PCWrite=0.
REQ-015 SHALL decode ImmSrc from op in every state: I-type/load 000, S 001, B 010, J 011, U 100, other 000.
REQ-016 SHALL make latencies lw/lbu 5, sw/sb 4, R/I/jal/lui 4, beq/bne 3, illegal 2 cycles, FETCH to FETCH.
REQ-017 SHALL make illegal combinational in DECODE, so it is exactly one cycle wide.

Reset
REQ-018 SHALL force state to FETCH immediately when rst_n=0, independent of clk.
REQ-019 SHALL hold PCWrite, IRWrite, MemWrite, RegWrite and illegal at 0 while rst_n=0.
REQ-020 SHALL make the first rising edge after rst_n deasserts execute FETCH normally.
REQ-021 SHALL abort any in-flight instruction on mid-instruction reset, with no further write enables.

Configuration
REQ-022 SHALL, when MEMRDY_EN is defined, add input mem_ready (1 bit) and make FETCH, MEMREAD and MEMWRITE hold until mem_ready=1.
REQ-023 SHALL, with MEMRDY_EN defined, assert IRWrite/PCWrite in FETCH only in the cycle mem_ready=1, and hold MemWrite for the whole MEMWRITE stay.
REQ-024 SHALL, without MEMRDY_EN, omit the mem_ready port and make every state last exactly one cycle.

Verification
REQ-025 SHALL cover lw: op=0000011 -> states 0,1,2,3,4,0; RegWrite=1 only in state 4, ResultSrc=01.
REQ-026 SHALL cover beq/bne: op=1100011, funct3=000, zero=1 -> PCWrite=1 in BRANCH; funct3=001, zero=1 -> PCWrite=0.
REQ-027 SHALL cover an illegal opcode: op=1111111 -> illegal=1 for one cycle in DECODE, next state FETCH, no RegWrite/MemWrite.
REQ-028 SHALL cover reset mid-store: rst_n low during MEMWRITE -> state=0 and MemWrite=0 without a clock edge.
REQ-029 SHALL cover the handshake (MEMRDY_EN): mem_ready=0 for 3 cycles in FETCH -> state stays 0 and IRWrite=0; on mem_ready=1, IRWrite=PCWrite=1, then DECODE.
REQ-030 SHALL cover sb: op=0100011, funct3=000 -> ByteEn=1 and MemWrite=1 in state 5.
